// File: rtl/mips_ctrl_monitor.sv
// Passive monitor for the multicycle MIPS control unit.
// Maps the raw control vector back to an FSM state each cycle, then flags
// signature/p_state disagreement, illegal state sequencing and PCEn misuse,
// and counts retired instructions. Drives nothing back into the datapath.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   IRWrite..PCEn     1-bit control outputs under observation
//   ALUSrcB, PCSrc    2-bit control outputs under observation
//   ALUControl        3-bit control output under observation
//   p_state           state reported by the control unit
//   OP, zero          current opcode, ALU zero flag
//   dec_state         registered decoded state (0..8, 4'hF = unknown)
//   err_sig/seq/pcen  one-cycle error pulses
//   err_sticky        accumulated {err_pcen, err_seq, err_sig}
//   retire_cnt        retired-instruction counter (wraps)
module mips_ctrl_monitor #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             IRWrite,
  input  logic             RegDst,
  input  logic             MemtoReg,
  input  logic             RegWrite,
  input  logic             ALUSrcA,
  input  logic             MemWrite,
  input  logic             PCEn,
  input  logic [1:0]       ALUSrcB,
  input  logic [1:0]       PCSrc,
  input  logic [2:0]       ALUControl,
  input  logic [3:0]       p_state,
  input  logic [5:0]       OP,
  input  logic             zero,
  output logic [3:0]       dec_state,
  output logic             err_sig,
  output logic             err_seq,
  output logic             err_pcen,
  output logic [2:0]       err_sticky,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecute  = 4'd6,
    StAluWb    = 4'd7,
    StBranch   = 4'd8,
    StUnknown  = 4'hF
  } state_e;

  localparam logic [5:0] OpLw  = 6'b100011;
  localparam logic [5:0] OpSw  = 6'b101011;
  localparam logic [5:0] OpR   = 6'b000000;
  localparam logic [5:0] OpBeq = 6'b000100;

  // {IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, MemWrite}_ALUSrcB_PCSrc_ALUControl
  logic [12:0] ctl;
  assign ctl = {IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, MemWrite,
                ALUSrcB, PCSrc, ALUControl};

  state_e           dec;
  state_e           dec_q;
  state_e           exp_q, exp_d;
  logic [5:0]       op_q;
  logic             op_bad;
  logic             sig_bad, seq_bad, pcen_bad, retire;
  logic             err_sig_q, err_seq_q, err_pcen_q;
  logic [2:0]       sticky_q;
  logic [CNT_W-1:0] cnt_q;

  // Signature decode, first match wins. PCEn only identifies Fetch; in the
  // other states it is left out so that misuse shows up as err_pcen rather
  // than as an unknown signature.
  always_comb begin
    dec = StUnknown;
    if (ctl == 13'b100000_01_00_010 && PCEn)     dec = StFetch;
    else if (ctl == 13'b000000_11_00_010)        dec = StDecode;
    else if (ctl == 13'b000010_10_00_010)        dec = StMemAdr;
    else if (ctl == 13'b000000_00_00_000)        dec = StMemRead;
    else if (ctl == 13'b001100_00_00_000)        dec = StMemWb;
    else if (ctl == 13'b000001_00_00_000)        dec = StMemWrite;
    else if (ctl[12:3] == 10'b000010_00_00)      dec = StExecute;
    else if (ctl == 13'b010100_00_00_000)        dec = StAluWb;
    else if (ctl == 13'b000010_00_01_110)        dec = StBranch;
  end

  // Expected successor is always derived from the actual decoded state, so
  // the checker resynchronises on its own after any error.
  always_comb begin
    exp_d  = StFetch;
    op_bad = 1'b0;
    case (dec)
      StFetch: exp_d = StDecode;
      StDecode: begin
        case (OP)
          OpLw, OpSw: exp_d = StMemAdr;
          OpR:        exp_d = StExecute;
          OpBeq:      exp_d = StBranch;
          default:    op_bad = 1'b1;
        endcase
      end
      StMemAdr: begin
        // Entered without a lw/sw capture: fall back to Fetch.
        if (op_q == OpLw)      exp_d = StMemRead;
        else if (op_q == OpSw) exp_d = StMemWrite;
      end
      StMemRead: exp_d = StMemWb;
      StExecute: exp_d = StAluWb;
      default:   exp_d = StFetch;
    endcase
  end

  always_comb begin
    sig_bad  = (dec != state_e'(p_state)) || (dec == StUnknown);
    seq_bad  = (dec != exp_q) || op_bad;
    pcen_bad = (dec == StBranch) ? (PCEn != zero)
                                 : (PCEn && dec != StFetch && dec != StUnknown);
    retire   = (dec == StFetch) &&
               (dec_q inside {StMemWb, StMemWrite, StAluWb, StBranch});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dec_q      <= StFetch;
      exp_q      <= StFetch;
      op_q       <= '0;
      err_sig_q  <= 1'b0;
      err_seq_q  <= 1'b0;
      err_pcen_q <= 1'b0;
      sticky_q   <= '0;
      cnt_q      <= '0;
    end else begin
      dec_q      <= dec;
      exp_q      <= exp_d;
      err_sig_q  <= sig_bad;
      err_seq_q  <= seq_bad;
      err_pcen_q <= pcen_bad;
      sticky_q   <= sticky_q | {pcen_bad, seq_bad, sig_bad};
      if (dec == StDecode) op_q <= OP;
      if (retire) cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign dec_state  = dec_q;
  assign err_sig    = err_sig_q;
  assign err_seq    = err_seq_q;
  assign err_pcen   = err_pcen_q;
  assign err_sticky = sticky_q;
  assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_mips_ctrl_monitor.sv
// Bench for mips_ctrl_monitor: directed scenarios with literal expectations,
// then randomized instruction streams with injected faults, all compared
// every cycle against a behavioural model.
module tb_mips_ctrl_monitor;

  localparam int CW = 8;  // narrow counter so the wrap scenario stays short

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          IRWrite = 0, RegDst = 0, MemtoReg = 0, RegWrite = 0;
  logic          ALUSrcA = 0, MemWrite = 0, PCEn = 0, zero = 0;
  logic [1:0]    ALUSrcB = 0, PCSrc = 0;
  logic [2:0]    ALUControl = 0;
  logic [3:0]    p_state = 0;
  logic [5:0]    OP = 0;
  logic [3:0]    dec_state;
  logic          err_sig, err_seq, err_pcen;
  logic [2:0]    err_sticky;
  logic [CW-1:0] retire_cnt;

  int errors = 0;
  int checks = 0;
  logic [12:0] garble = '0;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;

  mips_ctrl_monitor #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .MemWrite(MemWrite), .PCEn(PCEn),
    .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUControl(ALUControl), .p_state(p_state),
    .OP(OP), .zero(zero), .dec_state(dec_state), .err_sig(err_sig), .err_seq(err_seq),
    .err_pcen(err_pcen), .err_sticky(err_sticky), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  // Control vector each state is documented to drive (Execute uses ALU add here).
  function automatic logic [12:0] golden(input int s);
    case (s)
      0: return 13'b100000_01_00_010;
      1: return 13'b000000_11_00_010;
      2: return 13'b000010_10_00_010;
      3: return 13'b000000_00_00_000;
      4: return 13'b001100_00_00_000;
      5: return 13'b000001_00_00_000;
      6: return 13'b000010_00_00_010;
      7: return 13'b010100_00_00_000;
      default: return 13'b000010_00_01_110;
    endcase
  endfunction

  function automatic int mdecode(input logic [12:0] c, input logic pc);
    logic [12:0] m;
    for (int s = 0; s < 9; s++) begin
      m = (s == 6) ? 13'h1FF8 : 13'h1FFF;
      if (((c & m) == (golden(s) & m)) && (s != 0 || pc)) return s;
    end
    return 15;
  endfunction

  function automatic bit legal(input logic [5:0] op);
    return op == LW || op == SW || op == RT || op == BEQ;
  endfunction

  function automatic int succ(input int s, input logic [5:0] op);
    case (s)
      0: return 1;
      1: return (op == LW || op == SW) ? 2 : (op == RT) ? 6 : (op == BEQ) ? 8 : 0;
      2: return (op == LW) ? 3 : (op == SW) ? 5 : 0;
      3: return 4;
      6: return 7;
      default: return 0;
    endcase
  endfunction

  // Behavioural model
  int            md, m_dec, m_exp;
  logic          m_sb, m_qb, m_pb, m_sig, m_seq, m_pcen;
  logic [2:0]    m_sticky;
  logic [CW-1:0] m_cnt;
  logic [5:0]    m_op;

  always_comb begin
    md   = mdecode({IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, MemWrite,
                    ALUSrcB, PCSrc, ALUControl}, PCEn);
    m_sb = (md != int'(p_state)) || (md == 15);
    m_qb = (md != m_exp) || (md == 1 && !legal(OP));
    m_pb = (md == 8) ? (PCEn != zero) : (md >= 1 && md <= 7 && PCEn);
  end

  always @(posedge clk) begin
    if (reset) begin
      m_dec <= 0; m_exp <= 0; m_op <= '0; m_sig <= 0; m_seq <= 0; m_pcen <= 0;
      m_sticky <= '0; m_cnt <= '0;
    end else begin
      m_dec    <= md;
      m_sig    <= m_sb;
      m_seq    <= m_qb;
      m_pcen   <= m_pb;
      m_sticky <= m_sticky | {m_pb, m_qb, m_sb};
      m_exp    <= succ(md, (md == 1) ? OP : m_op);
      if (md == 1) m_op <= OP;
      if (md == 0 && (m_dec == 4 || m_dec == 5 || m_dec == 7 || m_dec == 8))
        m_cnt <= m_cnt + 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs, clock them in, then compare against the model.
  task automatic step(input int s, input logic [5:0] op, input logic z, input logic pc,
                      input logic [3:0] ps, input logic rst);
    logic [12:0] c;
    c = golden(s);
    if (s == 6) c[2:0] = 3'($urandom);
    c = c ^ garble;
    {IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, MemWrite, ALUSrcB, PCSrc, ALUControl} = c;
    OP = op; zero = z; PCEn = pc; p_state = ps; reset = rst;
    garble = '0;
    @(posedge clk); #1;
    check("dec_state",  32'(dec_state),  32'(m_dec));
    check("err_sig",    32'(err_sig),    32'(m_sig));
    check("err_seq",    32'(err_seq),    32'(m_seq));
    check("err_pcen",   32'(err_pcen),   32'(m_pcen));
    check("err_sticky", 32'(err_sticky), 32'(m_sticky));
    check("retire_cnt", 32'(retire_cnt), 32'(m_cnt));
  endtask

  // Legal cycle: PCEn high only in Fetch, p_state matches.
  task automatic go(input int s, input logic [5:0] op);
    step(s, op, 1'b0, s == 0, 4'(s), 1'b0);
  endtask

  initial begin
    int path[$];
    int kind, s;
    logic [5:0] op;
    logic z, pc;
    logic [3:0] ps;

    // Reset state
    step(0, RT, 0, 1, 0, 1);
    check("rst_dec", 32'(dec_state), 0);
    check("rst_sticky", 32'(err_sticky), 0);
    check("rst_cnt", 32'(retire_cnt), 0);

    // lw: S0..S4, S0
    for (int i = 0; i < 5; i++) begin
      go(i, LW);
      check("lw_dec", 32'(dec_state), 32'(i));
    end
    go(0, LW);
    check("lw_dec0", 32'(dec_state), 0);
    check("lw_cnt", 32'(retire_cnt), 1);
    check("lw_sticky", 32'(err_sticky), 0);

    // beq: PCEn matches zero, then PCEn without zero
    go(1, BEQ);
    step(8, BEQ, 1, 1, 8, 0);
    check("beq_ok_pcen", 32'(err_pcen), 0);
    go(0, BEQ);
    go(1, BEQ);
    step(8, BEQ, 0, 1, 8, 0);
    check("beq_bad_pcen", 32'(err_pcen), 1);
    check("beq_sticky", 32'(err_sticky), 3'b100);
    go(0, BEQ);
    check("beq_pcen_clr", 32'(err_pcen), 0);

    // R-type with wrong p_state in S7
    step(0, RT, 0, 1, 0, 1);
    go(0, RT); go(1, RT); go(6, RT);
    step(7, RT, 0, 0, 4'd6, 0);
    check("r_sig", 32'(err_sig), 1);
    check("r_seq", 32'(err_seq), 0);
    go(0, RT);
    check("r_sig_clr", 32'(err_sig), 0);
    check("r_seq_clr", 32'(err_seq), 0);

    // Unsupported opcode at Decode
    go(1, 6'b001000);
    check("badop_seq", 32'(err_seq), 1);
    go(0, 6'b001000);
    check("badop_resync", 32'(err_seq), 0);

    // Reset in the middle of lw
    go(1, LW); go(2, LW);
    step(3, LW, 0, 0, 3, 1);
    check("midrst_dec", 32'(dec_state), 0);
    check("midrst_sticky", 32'(err_sticky), 0);
    check("midrst_cnt", 32'(retire_cnt), 0);
    go(0, LW);
    check("midrst_s0_seq", 32'(err_seq), 0);
    check("midrst_s0_sticky", 32'(err_sticky), 0);

    // Counter wrap: 2^CW-1 beqs then one sw
    step(0, RT, 0, 1, 0, 1);
    for (int i = 0; i < (1 << CW) - 1; i++) begin
      go(0, BEQ); go(1, BEQ); step(8, BEQ, 0, 0, 8, 0);
    end
    go(0, SW);
    check("wrap_pre", 32'(retire_cnt), (1 << CW) - 1);
    go(1, SW); go(2, SW); go(5, SW); go(0, SW);
    check("wrap_cnt", 32'(retire_cnt), 0);
    check("wrap_sticky", 32'(err_sticky), 0);

    // Randomized instruction streams with injected faults
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0: begin op = LW; path = '{0, 1, 2, 3, 4}; end
        1: begin op = SW; path = '{0, 1, 2, 5}; end
        2: begin op = RT; path = '{0, 1, 6, 7}; end
        3: begin op = BEQ; path = '{0, 1, 8}; end
        default: begin
          op = 6'($urandom);
          if (legal(op)) op = 6'b001000;
          path = '{0, 1};
        end
      endcase
      foreach (path[k]) begin
        s  = path[k];
        z  = 1'($urandom);
        pc = (s == 0);
        if (s == 8) pc = ($urandom_range(0, 3) == 0) ? ~z : z;
        else if (s != 0 && $urandom_range(0, 14) == 0) pc = 1'b1;
        ps = ($urandom_range(0, 19) == 0) ? 4'($urandom) : 4'(s);
        if ($urandom_range(0, 24) == 0) garble = 13'(1) << $urandom_range(0, 12);
        step(s, op, z, pc, ps, $urandom_range(0, 99) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_ctrl_monitor.md
Name: mips_ctrl_monitor

Overview:
- Passive decoder and checker on the output side of the multicycle MIPS control unit.
- Every cycle it maps the raw control-signal vector back to one FSM state.
- It checks the decoded state against the reported p_state, the legal state sequence and the PCEn rule.
- It counts retired instructions. It sits beside the control unit in the top-level and the UVM environment and drives nothing back into the datapath.

Parameters:
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, MemWrite, PCEn  input  1 each  control outputs under observation
- ALUSrcB  input  2  control output under observation
- PCSrc  input  2  control output under observation
- ALUControl  input  3  control output under observation
- p_state  input  4  FSM state reported by the control unit
- OP  input  6  current instruction opcode
- zero  input  1  ALU zero flag
- dec_state  output  4  registered decoded state (0..8, 4'hF = unknown)
- err_sig  output  1  one-cycle pulse on signature/p_state mismatch
- err_seq  output  1  one-cycle pulse on illegal transition
- err_pcen  output  1  one-cycle pulse on PCEn violation
- err_sticky  output  3  OR-accumulated {err_pcen, err_seq, err_sig}
- retire_cnt  output  CNT_W  retired instructions

Behaviour:
- Reset (synchronous, active-high): dec_state=0, err_*=0, err_sticky=0, retire_cnt=0, expected state=S0, captured opcode=0. Reset takes priority over all updates, including mid-instruction.
- Signature decode (combinational, first match wins). Signals not listed must be 0.
  - S0 Fetch: IRWrite=1, ALUSrcA=0, ALUSrcB=01, PCSrc=00, ALUControl=010, PCEn=1.
  - S1 Decode: ALUSrcA=0, ALUSrcB=11, ALUControl=010.
  - S2 MemAdr: ALUSrcA=1, ALUSrcB=10, ALUControl=010.
  - S3 MemRead: all observed controls 0, ALUSrcB=00.
  - S4 MemWB: RegWrite=1, MemtoReg=1, RegDst=0.
  - S5 MemWrite: MemWrite=1.
  - S6 Execute: ALUSrcA=1, ALUSrcB=00, PCSrc=00; ALUControl not checked.
  - S7 ALUWB: RegWrite=1, RegDst=1, MemtoReg=0.
  - S8 Branch: ALUSrcA=1, ALUSrcB=00, PCSrc=01, ALUControl=110. PCEn is excluded from the S8 signature.
  - No match: 4'hF.
- Latency: all outputs are registered and reflect the inputs sampled one clock earlier.
- err_sig: fires when the decoded value ≠ p_state or the decoded value = 4'hF.
- Opcode capture: the opcode is captured when decoded=S1. lw=100011, sw=101011, R=000000, beq=000100.
- Sequence check (expected next state from the previous decoded state):
  - S0→S1.
  - S1→S2 for lw/sw, S6 for R, S8 for beq. Any other opcode fires err_seq at S1 and the expected state becomes S0.
  - S2→S3 for lw, S5 for sw.
  - S3→S4.
  - S6→S7.
  - S4, S5, S7, S8→S0.
  - err_seq fires when the decoded state ≠ expected.
  - After an error, resynchronise: expected is recomputed from the actual decoded state. Unknown resynchronises to S0.
  - The first cycle after reset expects S0.
- err_pcen: fires when decoded=S8 and PCEn≠zero, or decoded∈{S1..S7} and PCEn=1.
- Simultaneous errors: all applicable pulses assert in the same cycle. err_sticky ORs them in.
- retire_cnt: increments when decoded=S0 and the previous decoded state ∈ {S4, S5, S7, S8}. Wraps modulo 2^CNT_W with no saturation. An error in the same cycle does not block the increment.

Test Plan:
- Reset then lw sequence S0,S1,S2,S3,S4,S0 with matching p_state → dec_state tracks 0,1,2,3,4,0 one cycle late; retire_cnt=1; err_sticky=000.
- beq with zero=1 and PCEn=1 in S8, then zero=0 with PCEn=1 → no error first time; err_pcen pulse second time; err_sticky=100.
- R-type whose control vector in S7 is correct but p_state=6 → err_sig pulse one cycle later; sequence continues cleanly.
- OP=001000 at S1 → err_seq pulse; next S0 accepted without error.
- Preload 0xFFFF retires, then one sw (S0,S1,S2,S5,S0) → retire_cnt wraps to 0.
- Assert reset during S3 of lw → all outputs 0 next cycle; the following S0 is accepted and S4 is not expected.
